factorial_driver: RTL
=====================

# factorial_driver

Request-side front end for the `factorial` core. Upstream logic sends tagged `n` values over a valid/ready stream, buffered in a small FIFO. For each request the driver either issues a one-cycle `start` to the core and waits for `done`, or answers the request locally. Every request gets exactly one tagged response, and responses come back in request order.

## Interface
Parameters:
- `N_WIDTH`, 8: width of `n`; must match the core.
- `FN_WIDTH`, 32: width of `fn`; must match the core.
- `TAG_WIDTH`, 4: width of the request/response tag.
- `FIFO_DEPTH`, 4: request FIFO entries; power of two, at least 2.
- `MAX_N`, 12: largest `n` whose factorial fits in `FN_WIDTH` (12! = 479001600).
- `TIMEOUT_CYCLES`, 300: WAIT-state watchdog limit; used only with the timeout macro.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: request can be accepted.
- `req_n`, in, `N_WIDTH`: operand.
- `req_tag`, in, `TAG_WIDTH`: returned unchanged on the response.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: downstream accepts the response.
- `rsp_fn`, out, `FN_WIDTH`: result.
- `rsp_tag`, out, `TAG_WIDTH`: tag of the answered request.
- `rsp_ovf`, out, 1: `n > MAX_N`; `rsp_fn` = 0.
- `rsp_err`, out, 1: core timed out; `rsp_fn` = 0.
- `fact_start`, out, 1: to core `start`.
- `fact_n`, out, `N_WIDTH`: to core `n`.
- `fact_done`, in, 1: from core `done`.
- `fact_fn`, in, `FN_WIDTH`: from core `fn`.

## Operation
- Request push happens when `req_valid && req_ready`.
- `req_ready` = FIFO not full, and is 0 while `rst` is high.
- When the FIFO is full, a pop in the same cycle does not reopen `req_ready`.
- There is no fall-through: an entry pushed in cycle C is poppable at C+1 at the earliest.

FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**, FIFO not empty:
  - Pop the head into `cur_n` / `cur_tag`.
  - `cur_n == 0`: result 1, go to RESP. The core is not started, because it would count down through wrap-around.
  - `cur_n > MAX_N`: ovf=1, fn=0, go to RESP.
  - Otherwise go to ISSUE.
- **ISSUE**:
  - `fact_start` = 1 for exactly this cycle.
  - `fact_n` = `cur_n`, held stable from ISSUE through WAIT.
  - Go to WAIT.
- **WAIT**:
  - On `fact_done`, capture `fact_fn` into the result register and go to RESP.
  - `fact_done` outside WAIT is ignored.
- **RESP**:
  - `rsp_valid` = 1; `rsp_fn`, `rsp_tag`, `rsp_ovf`, `rsp_err` are stable until the handshake.
  - On `rsp_ready`, go to IDLE. A new pop can occur no earlier than the following cycle.

Width rules:
- `n` is compared to `MAX_N` unsigned, at full `N_WIDTH`.
- The `MAX_N` bound guarantees the core's product never wraps.

Reset, effective at the next edge:
- FSM goes to IDLE and the FIFO is emptied; in-flight and queued requests are discarded with no response.
- `fact_start`, `rsp_valid`, `rsp_ovf`, `rsp_err` = 0; `rsp_fn`, `rsp_tag`, `fact_n` = 0.
- The core shares `rst`, so both sides restart together.

## Timing
- Let P be the IDLE pop cycle. Then `fact_start` is high at P+1.
- The core response to that start:
  - LOAD at P+2.
  - ITER for n cycles, P+3 through P+n+2.
  - STOR at P+n+3.
  - `fact_done` at P+n+4.
- `rsp_valid` rises at P+n+5. Example: n=5 gives P+10; n=1 gives P+6.
- Local answers (n=0 or overflow): `rsp_valid` at P+1.
- Throughput is one request in flight. Back-to-back requests are separated by at least one IDLE cycle after the RESP handshake.

## Configuration
- **`FACT_DRV_TIMEOUT_EN` defined:**
  - A counter clears on ISSUE and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without `fact_done`: err=1, fn=0, go to RESP.
  - If `fact_done` arrives in the same cycle as the limit, `fact_done` wins.
- **Not defined:**
  - WAIT holds indefinitely.
  - `rsp_err` is tied to 0 and no counter is built.

## Structure
- Shared package/header `fact_pkg`:
  - FSM state encodings.
  - Default `N_WIDTH` / `FN_WIDTH` / `MAX_N` constants, shared with `factorial`.
- One sub-module, `fact_req_fifo`:
  - Synchronous FIFO with `FIFO_DEPTH` entries, each `N_WIDTH + TAG_WIDTH` wide.
  - Ports: push, pop, full, empty, head data.
  - Synchronous reset to empty.

## Test plan
- **n=5, tag=3**, `rsp_ready` held high → `fact_start` pulses once at P+1; `rsp_valid` at P+10 with fn=120, tag=3, ovf=0, err=0.
- **n=0, then n=1** → first: fn=1 at P+1, no `fact_start`. Second: fn=1 at P+6.
- **n=13** → ovf=1, fn=0 at P+1, no `fact_start`. **n=12** → fn=479001600.
- **Six requests pushed with `rsp_ready` low** → `req_ready` drops once the FIFO is full (4 entries). Raising `rsp_ready` returns the responses in tag order, with correct fn for n=3,4,6,7 (6, 24, 720, 5040).
- **Timeout build, core stub holding `fact_done` = 0** → err=1, fn=0 after `TIMEOUT_CYCLES` WAIT cycles. The next request proceeds normally.
- **`rst` asserted during WAIT (n=10)** → next cycle: IDLE, `req_ready` returns high, `rsp_valid` = 0, and no stale response ever appears.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared constants and FSM encoding for the factorial core and its request driver.
package fact_pkg;

  localparam int FACT_N_WIDTH  = 8;
  localparam int FACT_FN_WIDTH = 32;
  // Largest n whose factorial fits in FACT_FN_WIDTH bits (12! = 479001600).
  localparam int FACT_MAX_N    = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } fact_drv_state_e;

endpackage : fact_pkg

// File: rtl/fact_req_fifo.sv
// Request FIFO for the factorial driver: registered storage, no fall-through,
// push ignored when full, pop ignored when empty, synchronous reset to empty.
module fact_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_dat_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign head_dat_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule : fact_req_fifo

// File: rtl/factorial_driver.sv
// Request front end for the factorial core: FIFO-buffered tagged requests, one in flight,
// in-order tagged responses. Define FACT_DRV_TIMEOUT_EN to build the WAIT-state watchdog.
module factorial_driver
  import fact_pkg::*;
#(
  parameter int N_WIDTH    = FACT_N_WIDTH,
  parameter int FN_WIDTH   = FACT_FN_WIDTH,
  parameter int TAG_WIDTH  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_N      = FACT_MAX_N
`ifdef FACT_DRV_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 300
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [N_WIDTH-1:0]   req_n,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [FN_WIDTH-1:0]  rsp_fn,
  output logic [TAG_WIDTH-1:0] rsp_tag,
  output logic                 rsp_ovf,
  output logic                 rsp_err,
  output logic                 fact_start,
  output logic [N_WIDTH-1:0]   fact_n,
  input  logic                 fact_done,
  input  logic [FN_WIDTH-1:0]  fact_fn
);

  localparam int               ENT_W     = N_WIDTH + TAG_WIDTH;
  localparam logic [N_WIDTH-1:0] MAX_N_W = N_WIDTH'(MAX_N);

  fact_drv_state_e        state_q, state_d;
  logic [N_WIDTH-1:0]     cur_n_q, cur_n_d;
  logic [TAG_WIDTH-1:0]   cur_tag_q, cur_tag_d;
  logic [FN_WIDTH-1:0]    result_q, result_d;
  logic                   ovf_q, ovf_d;

  logic                   fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [ENT_W-1:0]       fifo_head;
  logic [N_WIDTH-1:0]     head_n;
  logic [TAG_WIDTH-1:0]   head_tag;

  assign req_ready = !fifo_full && !rst;
  assign fifo_push = req_valid && req_ready;
  assign head_n    = fifo_head[ENT_W-1:TAG_WIDTH];
  assign head_tag  = fifo_head[TAG_WIDTH-1:0];

  fact_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_req_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .push_dat_i ({req_n, req_tag}),
    .pop_i      (fifo_pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_dat_o (fifo_head)
  );

`ifdef FACT_DRV_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    cur_n_d    = cur_n_q;
    cur_tag_d  = cur_tag_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    fifo_pop   = 1'b0;
    fact_start = 1'b0;
`ifdef FACT_DRV_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          cur_n_d   = head_n;
          cur_tag_d = head_tag;
          ovf_d     = 1'b0;
          result_d  = '0;
`ifdef FACT_DRV_TIMEOUT_EN
          err_d     = 1'b0;
`endif
          // n == 0 is answered here: the core would count down through wrap-around.
          if (head_n == '0) begin
            result_d = FN_WIDTH'(1);
            state_d  = ST_RESP;
          end else if (head_n > MAX_N_W) begin
            ovf_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        fact_start = 1'b1;
        state_d    = ST_WAIT;
`ifdef FACT_DRV_TIMEOUT_EN
        to_cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (fact_done) begin
          result_d = fact_fn;
          state_d  = ST_RESP;
        end
`ifdef FACT_DRV_TIMEOUT_EN
        // The watchdog fires after TIMEOUT_CYCLES WAIT cycles; a coincident done wins.
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = ST_RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_n_q   <= '0;
      cur_tag_q <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_n_q   <= cur_n_d;
      cur_tag_q <= cur_tag_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef FACT_DRV_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_fn    = result_q;
  assign rsp_tag   = cur_tag_q;
  assign rsp_ovf   = ovf_q;
  assign fact_n    = cur_n_q;

endmodule : factorial_driver
